// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite mappers on the VGA pixel path.
package sprite_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    typedef logic [9:0]  coord_t;
    typedef logic [10:0] coord_ext_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb4_t;

endpackage

// File: rtl/sprite_anim_mapper_if.sv
// ROM and palette bus between a sprite mapper (master) and one sprite asset (slave).
interface sprite_anim_mapper_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned IDX_W  = 5
);

    logic [ADDR_W-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_q;
    logic [3:0]        palette_red;
    logic [3:0]        palette_green;
    logic [3:0]        palette_blue;

    modport master (
        output rom_addr,
        input  rom_q,
        input  palette_red,
        input  palette_green,
        input  palette_blue
    );

    modport slave (
        input  rom_addr,
        output rom_q,
        output palette_red,
        output palette_green,
        output palette_blue
    );

endinterface

// File: rtl/sprite_anim_ctr.sv
// Animation tick counter and frame base accumulator for a multi-frame sprite ROM.
module sprite_anim_ctr #(
    parameter int unsigned FRAMES     = 2,
    parameter int unsigned FRAME_SIZE = 945,
    parameter int unsigned ADDR_W     = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic              anim_en,
    input  logic [5:0]        anim_period,
    output logic [ADDR_W-1:0] frame_base
);

    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(FRAME_SIZE);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((FRAMES - 1) * FRAME_SIZE);

    logic [5:0] cnt;
    logic [5:0] limit;

    // A period of 0 behaves as 1, so the frame advances on every tick.
    always_comb begin
        limit = '0;
        if (anim_period != '0) begin
            limit = anim_period - 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            frame_base <= '0;
        end else if (frame_tick && anim_en) begin
            if (cnt >= limit) begin
                cnt        <= '0;
                frame_base <= (frame_base >= LAST_BASE) ? '0 : frame_base + STEP;
            end else begin
                cnt <= cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_anim_mapper.sv
// Positioned, upscaled, animated sprite mapper; 3-edge pixel latency.
// Define SPRITE_MIRROR_EN to enable horizontal mirroring.
module sprite_anim_mapper
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W           = 21,
    parameter int unsigned SPR_H           = 45,
    parameter int unsigned FRAMES          = 2,
    parameter int unsigned SCALE_SH        = 2,
    parameter int unsigned ADDR_W          = 11,
    parameter int unsigned IDX_W           = 5,
    parameter int unsigned TRANSPARENT_IDX = 0
) (
    input  logic                 vga_clk,
    input  logic                 reset_n,
    input  coord_t               DrawX,
    input  coord_t               DrawY,
    input  logic                 blank,
    input  logic                 frame_tick,
    input  coord_t               sprite_x,
    input  coord_t               sprite_y,
    input  logic                 mirror,
    input  logic                 anim_en,
    input  logic [5:0]           anim_period,
    sprite_anim_mapper_if.master rom,
    output logic [3:0]           red,
    output logic [3:0]           green,
    output logic [3:0]           blue,
    output logic                 hit
);

    localparam int unsigned       FRAME_SIZE = SPR_W * SPR_H;
    localparam coord_ext_t        BOX_W      = coord_ext_t'(SPR_W << SCALE_SH);
    localparam coord_ext_t        BOX_H      = coord_ext_t'(SPR_H << SCALE_SH);
    localparam logic [ADDR_W-1:0] SPR_W_A    = ADDR_W'(SPR_W);
    localparam logic [IDX_W-1:0]  TRANSP     = IDX_W'(TRANSPARENT_IDX);

    coord_t            pos_x;
    coord_t            pos_y;
    logic              mir;
    logic [ADDR_W-1:0] frame_base;
    coord_ext_t        dx;
    coord_ext_t        dy;
    logic              in_box;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] addr_next;
    logic              box_d0;
    logic              box_d1;
    rgb4_t             rgb_q;

    sprite_anim_ctr #(
        .FRAMES     (FRAMES),
        .FRAME_SIZE (FRAME_SIZE),
        .ADDR_W     (ADDR_W)
    ) u_anim_ctr (
        .clk         (vga_clk),
        .rst_n       (reset_n),
        .frame_tick  (frame_tick),
        .anim_en     (anim_en),
        .anim_period (anim_period),
        .frame_base  (frame_base)
    );

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_x <= '0;
            pos_y <= '0;
        end else if (frame_tick) begin
            pos_x <= sprite_x;
            pos_y <= sprite_y;
        end
    end

`ifdef SPRITE_MIRROR_EN
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            mir <= 1'b0;
        end else if (frame_tick) begin
            mir <= mirror;
        end
    end
`else
    // Constant 0: the mirror subtractor below folds away; the port stays for pin compatibility.
    assign mir = mirror & 1'b0;
`endif

    always_comb begin
        dx     = coord_ext_t'(DrawX) - coord_ext_t'(pos_x);
        dy     = coord_ext_t'(DrawY) - coord_ext_t'(pos_y);
        in_box = blank && (DrawX >= pos_x) && (DrawY >= pos_y) && (dx < BOX_W) && (dy < BOX_H);
        col    = ADDR_W'(dx >> SCALE_SH);
        row    = ADDR_W'(dy >> SCALE_SH);
        if (mir) begin
            col = SPR_W_A - ADDR_W'(1) - col;
        end
        addr_next = frame_base;
        if (in_box) begin
            addr_next = frame_base + row * SPR_W_A + col;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom.rom_addr <= '0;
            box_d0       <= 1'b0;
            box_d1       <= 1'b0;
            rgb_q        <= '0;
            hit          <= 1'b0;
        end else begin
            rom.rom_addr <= addr_next;
            box_d0       <= in_box;
            box_d1       <= box_d0;
            if (box_d1 && (rom.rom_q != TRANSP)) begin
                hit   <= 1'b1;
                rgb_q <= '{r: rom.palette_red, g: rom.palette_green, b: rom.palette_blue};
            end else begin
                hit   <= 1'b0;
                rgb_q <= '0;
            end
        end
    end

    assign red   = rgb_q.r;
    assign green = rgb_q.g;
    assign blue  = rgb_q.b;

endmodule

// File: tb/tb_sprite_anim_mapper.sv
// Directed bench for sprite_anim_mapper with a synchronous ROM and combinational palette model.
module tb_sprite_anim_mapper;
    import sprite_pkg::*;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b1;
    coord_t     DrawX = '0;
    coord_t     DrawY = '0;
    logic       blank = 1'b0;
    logic       frame_tick = 1'b0;
    coord_t     sprite_x = '0;
    coord_t     sprite_y = '0;
    logic       mirror = 1'b0;
    logic       anim_en = 1'b0;
    logic [5:0] anim_period = 6'd1;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       hit;
    logic       transp = 1'b0;

    int checks = 0;
    int errors = 0;

    sprite_anim_mapper_if #(.ADDR_W(11), .IDX_W(5)) bus ();

    sprite_anim_mapper dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .frame_tick  (frame_tick),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .mirror      (mirror),
        .anim_en     (anim_en),
        .anim_period (anim_period),
        .rom         (bus),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hit         (hit)
    );

    always #5 vga_clk = ~vga_clk;

    // ROM content: index = addr % 31 + 1 (never transparent unless forced)
    always @(posedge vga_clk) begin
        bus.rom_q <= transp ? 5'd0 : 5'((bus.rom_addr % 31) + 1);
    end
    assign bus.palette_red   = bus.rom_q[3:0];
    assign bus.palette_green = ~bus.rom_q[3:0];
    assign bus.palette_blue  = {bus.rom_q[4], 3'b101};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int x, input int y, input logic m);
        @(negedge vga_clk);
        sprite_x   = 10'(x);
        sprite_y   = 10'(y);
        mirror     = m;
        blank      = 1'b0;
        frame_tick = 1'b1;
        @(negedge vga_clk);
        frame_tick = 1'b0;
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic b,
                       input int exp_addr, input logic exp_hit, input logic [11:0] exp_rgb);
        @(negedge vga_clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        @(posedge vga_clk);
        #1;
        check_eq({tag, "_addr"}, 32'(bus.rom_addr), 32'(exp_addr));
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        check_eq({tag, "_hit"}, 32'(hit), 32'(exp_hit));
        check_eq({tag, "_rgb"}, 32'({red, green, blue}), 32'(exp_rgb));
    endtask

    initial begin
        #3 reset_n = 1'b0;
        #1;
        check_eq("rst_addr", 32'(bus.rom_addr), 32'd0);
        check_eq("rst_hit", 32'(hit), 32'd0);
        check_eq("rst_rgb", 32'({red, green, blue}), 32'd0);
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;

        tick(100, 50, 1'b0);
        pix("origin", 100, 50, 1'b1, 0, 1'b1, 12'h1E5);
        pix("right_edge", 183, 50, 1'b1, 20, 1'b1, 12'h5AD);
        pix("right_out", 184, 50, 1'b1, 0, 1'b0, 12'h000);
        pix("left_out", 99, 50, 1'b1, 0, 1'b0, 12'h000);
        pix("bottom_out", 100, 230, 1'b1, 0, 1'b0, 12'h000);

        tick(630, 50, 1'b0);
        pix("no_wrap", 639, 50, 1'b1, 2, 1'b1, 12'h3C5);
        tick(100, 50, 1'b0);

        anim_period = 6'd3;
        anim_en     = 1'b1;
        tick(100, 50, 1'b0);
        pix("anim_t1", 100, 50, 1'b1, 0, 1'b1, 12'h1E5);
        tick(100, 50, 1'b0);
        tick(100, 50, 1'b0);
        pix("anim_f1", 100, 50, 1'b1, 945, 1'b1, 12'h0FD);
        pix("anim_f1_out", 10, 10, 1'b1, 945, 1'b0, 12'h000);
        repeat (3) tick(100, 50, 1'b0);
        pix("anim_wrap", 100, 50, 1'b1, 0, 1'b1, 12'h1E5);
        anim_period = 6'd0;
        tick(100, 50, 1'b0);
        pix("period0", 100, 50, 1'b1, 945, 1'b1, 12'h0FD);
        tick(100, 50, 1'b0);
        anim_en = 1'b0;
        tick(100, 50, 1'b0);
        pix("anim_hold", 100, 50, 1'b1, 0, 1'b1, 12'h1E5);

        tick(100, 50, 1'b1);
`ifdef SPRITE_MIRROR_EN
        pix("mirror", 100, 50, 1'b1, 20, 1'b1, 12'h5AD);
        @(negedge vga_clk);
        mirror = 1'b0;
        pix("mirror_held", 100, 50, 1'b1, 20, 1'b1, 12'h5AD);
`else
        pix("mirror_off", 100, 50, 1'b1, 0, 1'b1, 12'h1E5);
`endif
        tick(100, 50, 1'b0);

        transp = 1'b1;
        pix("transparent", 100, 50, 1'b1, 0, 1'b0, 12'h000);
        transp = 1'b0;
        pix("blanked", 100, 50, 1'b0, 0, 1'b0, 12'h000);

        pix("pre_rst", 110, 60, 1'b1, 44, 1'b1, 12'hE15);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_addr", 32'(bus.rom_addr), 32'd0);
        check_eq("midrst_hit", 32'(hit), 32'd0);
        check_eq("midrst_rgb", 32'({red, green, blue}), 32'd0);
        @(negedge vga_clk);
        DrawX = '0;
        DrawY = '0;
        blank = 1'b1;
        @(negedge vga_clk);
        reset_n = 1'b1;
        @(posedge vga_clk);
        #1;
        check_eq("post_e0_addr", 32'(bus.rom_addr), 32'd0);
        check_eq("post_e0_hit", 32'(hit), 32'd0);
        @(posedge vga_clk);
        #1;
        check_eq("post_e1_hit", 32'(hit), 32'd0);
        @(posedge vga_clk);
        #1;
        check_eq("post_e2_hit", 32'(hit), 32'd1);
        check_eq("post_e2_rgb", 32'({red, green, blue}), 32'h1E5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_anim_mapper.md
# sprite_anim_mapper

Parametrised, animated, positioned sprite mapper for the VGA pixel path. It places a multi-frame sprite ROM image at a runtime screen position with power-of-two upscaling, optional horizontal mirroring and a transparent palette index. It cycles animation frames on frame ticks from the VGA controller. Its output feeds the colour-priority mux ahead of the DAC.

## Interface
Parameters:
- SPR_W, 21: sprite width in ROM pixels
- SPR_H, 45: sprite height in ROM pixels
- FRAMES, 2: animation frames stored back-to-back in ROM
- SCALE_SH, 2: screen pixels per ROM pixel = 2**SCALE_SH, on both axes
- ADDR_W, 11: ROM address width; must hold FRAMES*SPR_W*SPR_H
- IDX_W, 5: palette index width
- TRANSPARENT_IDX, 0: palette index treated as see-through

Ports:
- vga_clk  in  1: pixel clock
- reset_n  in  1: asynchronous, active-low reset
- DrawX, DrawY  in  10 each: current pixel coordinates
- blank  in  1: 1 = active video
- frame_tick  in  1: one-cycle pulse per frame at vblank start
- sprite_x, sprite_y  in  10 each: requested top-left screen position
- mirror  in  1: requested horizontal flip
- anim_en  in  1: 1 = advance animation
- anim_period  in  6: frame_ticks per animation frame
- rom_addr  out  ADDR_W: registered address to the external synchronous ROM (1-cycle read)
- rom_q  in  IDX_W: ROM data
- palette_red, palette_green, palette_blue  in  4 each: combinational palette output for rom_q
- red, green, blue  out  4 each: registered colour
- hit  out  1: registered; 1 = opaque sprite pixel

## Operation
- Shadow registers pos_x, pos_y and mir load from sprite_x, sprite_y and mirror only on frame_tick. No tearing mid-frame.
- Animation counter cnt:
  - Increments on a frame_tick with anim_en=1.
  - On the tick where cnt >= max(anim_period,1)-1, cnt returns to 0 and frame_base += SPR_W*SPR_H, wrapping to 0 after frame FRAMES-1.
  - anim_en=0 holds cnt and frame_base.
  - A change to anim_period takes effect at the next tick.
- Box test uses 11-bit unsigned arithmetic, so no wrap at the right or bottom edge:
  - dx = DrawX - pos_x
  - dy = DrawY - pos_y
  - in_box = DrawX >= pos_x, DrawY >= pos_y, dx < SPR_W<<SCALE_SH, dy < SPR_H<<SCALE_SH, and blank=1
- Address:
  - col = dx>>SCALE_SH; if mir, col = SPR_W-1-col
  - row = dy>>SCALE_SH
  - rom_addr = frame_base + row*SPR_W + col
  - Outside the box, rom_addr = frame_base.
- Output: if in_box (delayed) and rom_q != TRANSPARENT_IDX, then hit=1 and red/green/blue = palette values; otherwise hit=0 and red/green/blue=0.
- No division. All multiplies are by elaboration-time constants.

## Timing
- Pipeline, with inputs stable before edge E0:
  - E0: rom_addr and in_box flag registered.
  - E1: ROM presents rom_q; in_box delayed one stage.
  - E2: red, green, blue and hit registered.
  - Fixed latency 3 edges; the VGA controller delays sync signals to match.
- A frame_tick on the same edge as a pixel: the pixel sampled at that edge uses the old shadow/frame_base; the new values apply from the next edge.
- Reset (asserted at any time, including mid-line):
  - Immediately zeroes rom_addr, red, green, blue, hit, the pipeline flags, cnt, frame_base, pos_x, pos_y and mir.
  - After release, outputs stay 0 until a valid in-box pixel has traversed the full pipeline.

## Configuration
- SPRITE_MIRROR_EN defined: mirror is latched and applied as above.
- SPRITE_MIRROR_EN undefined: the mirror port is present but ignored, mir is tied to 0 and the subtractor is removed.

## Structure
- Shared package sprite_pkg holds:
  - H_ACTIVE=640, V_ACTIVE=480
  - Coordinate type coord_t (10 bits) and widened coordinate type coord_ext_t (11 bits)
  - rgb4_t struct (r, g, b)
- Sub-module sprite_anim_ctr contains cnt, the frame_base accumulator and wrap logic. Parameters: FRAMES, frame size, ADDR_W.
- The ROM and palette stay outside, one per sprite asset. The mapper is shared across assets.

## Test plan
All scenarios use defaults, pos (100,50), anim_en=0, with a frame_tick applied first.
- Origin pixel: DrawX=100, DrawY=50, blank=1 -> rom_addr=0 after E0; red/green/blue = palette(rom_q) and hit=1 after E2.
- Right edge and bounds:
  - DrawX=183, DrawY=50 -> rom_addr=20.
  - DrawX=184 -> hit=0 and rgb=0 three edges later.
  - DrawX=99 -> hit=0.
  - pos_x=630, DrawX=639 -> in box, no wrap.
- Animation: anim_period=3, anim_en=1 -> three frame_ticks give frame_base=945 and pixel (100,50) gives rom_addr=945; three more give frame_base=0.
- Mirror: mirror=1 latched, DrawX=100 -> rom_addr=20; mirror toggled mid-frame without a frame_tick -> rom_addr unchanged.
- Transparency and blank: rom_q=0 -> hit=0, rgb=0; blank=0 inside the box -> hit=0.
- Reset: assert reset_n=0 mid-line with hit=1 -> outputs 0 immediately; after release with no frame_tick, pos=(0,0) and pixel (0,0) -> rom_addr=0.
